// File: rtl/id_ex_pipe_sb_if.sv
// Decode-to-EX bundle for id_ex_pipe_sb: decode-side instruction fields in, registered EX-side fields out.
// ex_hold is EX's "not ready": while high the ID/EX register keeps its contents, and stall tells decode
// that its slot was not consumed this cycle. Decode must keep the same instruction presented until stall
// is low at a rising edge. A decode instruction is consumed on any edge where stall=0 and flush=0.
interface id_ex_pipe_sb_if #(
  parameter int DATA_W = 230,
  parameter int REG_AW = 5
);
  logic              id_valid;
  logic [DATA_W-1:0] id_payload;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_rs_used;
  logic              id_rt_used;
  logic              id_mem_read;
  logic [REG_AW-1:0] id_dst;
  logic              ex_hold;
  logic              flush;
  logic              stall;
  logic              ex_valid;
  logic [DATA_W-1:0] ex_payload;
  logic [REG_AW-1:0] ex_dst;
  logic              ex_mem_read;

  modport master (
    output id_valid, id_payload, id_rs, id_rt, id_rs_used, id_rt_used, id_mem_read, id_dst,
    output ex_hold, flush,
    input  stall, ex_valid, ex_payload, ex_dst, ex_mem_read
  );

  modport slave (
    input  id_valid, id_payload, id_rs, id_rt, id_rs_used, id_rt_used, id_mem_read, id_dst,
    input  ex_hold, flush,
    output stall, ex_valid, ex_payload, ex_dst, ex_mem_read
  );
endinterface

// File: rtl/id_ex_pipe_sb.sv
// ID/EX pipeline register with a LOAD_LAT-deep load scoreboard for load-use stalls.
// Define ID_EX_STATS_EN to implement the saturating bubble counter; otherwise bubble_cnt is 0.
module id_ex_pipe_sb #(
  parameter int DATA_W   = 230,
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  id_ex_pipe_sb_if.slave   pif,
  output logic [CNT_W-1:0] bubble_cnt
);

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] dst;
  } sb_slot_t;

  // sb_q[0] is the load sitting in ID/EX; higher slots are older loads further down.
  sb_slot_t [LOAD_LAT-1:0] sb_q, sb_d;

  logic              ex_valid_q, ex_valid_d;
  logic [DATA_W-1:0] ex_payload_q, ex_payload_d;
  logic [REG_AW-1:0] ex_dst_q, ex_dst_d;
  logic              ex_mem_read_q, ex_mem_read_d;
  logic              match;
  logic              hazard;

  always_comb begin
    match = 1'b0;
    for (int k = 0; k < LOAD_LAT; k++) begin
      if (sb_q[k].v &&
          ((pif.id_rs_used && (pif.id_rs != '0) && (pif.id_rs == sb_q[k].dst)) ||
           (pif.id_rt_used && (pif.id_rt != '0) && (pif.id_rt == sb_q[k].dst)))) begin
        match = 1'b1;
      end
    end
  end

  assign hazard    = pif.id_valid & match;
  assign pif.stall = ~pif.flush & (pif.ex_hold | hazard);

  always_comb begin
    ex_valid_d    = ex_valid_q;
    ex_payload_d  = ex_payload_q;
    ex_dst_d      = ex_dst_q;
    ex_mem_read_d = ex_mem_read_q;
    sb_d          = sb_q;
    if (!pif.ex_hold) begin
      for (int k = LOAD_LAT - 1; k > 0; k--) begin
        sb_d[k] = sb_q[k-1];
      end
      sb_d[0] = '0;
      if (pif.flush || hazard) begin
        ex_valid_d    = 1'b0;
        ex_payload_d  = '0;
        ex_dst_d      = '0;
        ex_mem_read_d = 1'b0;
      end else begin
        ex_valid_d    = pif.id_valid;
        ex_payload_d  = pif.id_payload;
        ex_dst_d      = pif.id_dst;
        ex_mem_read_d = pif.id_mem_read;
        // Loads to r0 never produce a value anyone waits for.
        sb_d[0].v     = pif.id_valid & pif.id_mem_read & (pif.id_dst != '0);
        sb_d[0].dst   = pif.id_dst;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_q    <= 1'b0;
      ex_payload_q  <= '0;
      ex_dst_q      <= '0;
      ex_mem_read_q <= 1'b0;
      sb_q          <= '0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_payload_q  <= ex_payload_d;
      ex_dst_q      <= ex_dst_d;
      ex_mem_read_q <= ex_mem_read_d;
      sb_q          <= sb_d;
    end
  end

  assign pif.ex_valid    = ex_valid_q;
  assign pif.ex_payload  = ex_payload_q;
  assign pif.ex_dst      = ex_dst_q;
  assign pif.ex_mem_read = ex_mem_read_q;

`ifdef ID_EX_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bubble_ins;

  // Only hazard bubbles count; hold and flush take priority over a hazard.
  assign bubble_ins = hazard & ~pif.ex_hold & ~pif.flush;

  always_comb begin
    cnt_d = cnt_q;
    if (bubble_ins && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bubble_cnt = cnt_q;
`else
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_pipe_sb.sv
// Bench for id_ex_pipe_sb: one instance with LOAD_LAT=1/CNT_W=3 (index 0), one with LOAD_LAT=3/CNT_W=16 (index 1).
// Directed scenario tasks plus a randomized in-order scoreboard run with a time-based load-use model.
module tb_id_ex_pipe_sb;
  localparam int DW = 32;
`ifdef ID_EX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic          id_valid [2];
  logic [DW-1:0] id_payload [2];
  logic [4:0]    id_rs [2];
  logic [4:0]    id_rt [2];
  logic [4:0]    id_dst [2];
  logic          id_rs_used [2];
  logic          id_rt_used [2];
  logic          id_mem_read [2];
  logic          ex_hold [2];
  logic          flush [2];
  logic          stall_o [2];
  logic          ex_valid_o [2];
  logic          ex_mr_o [2];
  logic [DW-1:0] ex_payload_o [2];
  logic [4:0]    ex_dst_o [2];
  logic [15:0]   cnt_o [2];
  logic [2:0]    bc1;
  logic [15:0]   bc3;

  int total = 0;
  int bad = 0;
  int exp_cnt [2];
  logic [DW-1:0] exp_q[$];

  id_ex_pipe_sb_if #(.DATA_W(DW), .REG_AW(5)) if1 ();
  id_ex_pipe_sb_if #(.DATA_W(DW), .REG_AW(5)) if3 ();

  id_ex_pipe_sb #(.DATA_W(DW), .REG_AW(5), .LOAD_LAT(1), .CNT_W(3)) u1 (
    .clk(clk), .reset(reset), .pif(if1), .bubble_cnt(bc1));
  id_ex_pipe_sb #(.DATA_W(DW), .REG_AW(5), .LOAD_LAT(3), .CNT_W(16)) u3 (
    .clk(clk), .reset(reset), .pif(if3), .bubble_cnt(bc3));

  assign if1.id_valid = id_valid[0];       assign if3.id_valid = id_valid[1];
  assign if1.id_payload = id_payload[0];   assign if3.id_payload = id_payload[1];
  assign if1.id_rs = id_rs[0];             assign if3.id_rs = id_rs[1];
  assign if1.id_rt = id_rt[0];             assign if3.id_rt = id_rt[1];
  assign if1.id_rs_used = id_rs_used[0];   assign if3.id_rs_used = id_rs_used[1];
  assign if1.id_rt_used = id_rt_used[0];   assign if3.id_rt_used = id_rt_used[1];
  assign if1.id_mem_read = id_mem_read[0]; assign if3.id_mem_read = id_mem_read[1];
  assign if1.id_dst = id_dst[0];           assign if3.id_dst = id_dst[1];
  assign if1.ex_hold = ex_hold[0];         assign if3.ex_hold = ex_hold[1];
  assign if1.flush = flush[0];             assign if3.flush = flush[1];
  assign stall_o[0] = if1.stall;           assign stall_o[1] = if3.stall;
  assign ex_valid_o[0] = if1.ex_valid;     assign ex_valid_o[1] = if3.ex_valid;
  assign ex_payload_o[0] = if1.ex_payload; assign ex_payload_o[1] = if3.ex_payload;
  assign ex_dst_o[0] = if1.ex_dst;         assign ex_dst_o[1] = if3.ex_dst;
  assign ex_mr_o[0] = if1.ex_mem_read;     assign ex_mr_o[1] = if3.ex_mem_read;
  assign cnt_o[0] = {13'd0, bc1};          assign cnt_o[1] = bc3;

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input int u, input logic v, input logic [DW-1:0] pl,
                           input logic [4:0] rs, input logic rsu, input logic [4:0] rt,
                           input logic rtu, input logic mr, input logic [4:0] dst);
    id_valid[u] = v; id_payload[u] = pl; id_rs[u] = rs; id_rs_used[u] = rsu;
    id_rt[u] = rt; id_rt_used[u] = rtu; id_mem_read[u] = mr; id_dst[u] = dst;
  endtask

  task automatic set_idle(input int u);
    set_instr(u, 1'b0, '0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    ex_hold[u] = 1'b0;
    flush[u] = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_idle(0);
    set_idle(1);
    cyc();
    reset = 1'b0;
    exp_cnt[0] = 0;
    exp_cnt[1] = 0;
  endtask

  // reference counter model: saturates at 7 for instance 0, 65535 for instance 1
  task automatic bump(input int u);
    if (exp_cnt[u] < ((u == 0) ? 7 : 65535)) exp_cnt[u]++;
  endtask

  function automatic logic [15:0] cnt_exp(input int u);
    return STATS ? 16'(exp_cnt[u]) : 16'd0;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    for (int u = 0; u < 2; u++) begin
      set_instr(u, 1'b1, 32'hDEAD_BEEF, 5'd8, 1'b1, 5'd8, 1'b1, 1'b1, 5'd8);
      ex_hold[u] = 1'b0;
      flush[u] = 1'b0;
    end
    cyc();
    exp_cnt[0] = 0;
    exp_cnt[1] = 0;
    #1;
    for (int u = 0; u < 2; u++) begin
      total++; if (ex_valid_o[u] !== 1'b0) begin bad++; $display("FAIL rst_ex_valid u=%0d got=%0b exp=0", u, ex_valid_o[u]); end
      total++; if (ex_payload_o[u] !== '0) begin bad++; $display("FAIL rst_payload u=%0d got=%h exp=0", u, ex_payload_o[u]); end
      total++; if (ex_dst_o[u] !== 5'd0) begin bad++; $display("FAIL rst_dst u=%0d got=%0d exp=0", u, ex_dst_o[u]); end
      total++; if (ex_mr_o[u] !== 1'b0) begin bad++; $display("FAIL rst_mem_read u=%0d got=%0b exp=0", u, ex_mr_o[u]); end
      total++; if (stall_o[u] !== 1'b0) begin bad++; $display("FAIL rst_stall u=%0d got=%0b exp=0", u, stall_o[u]); end
      total++; if (cnt_o[u] !== cnt_exp(u)) begin bad++; $display("FAIL rst_cnt u=%0d got=%0d exp=%0d", u, cnt_o[u], cnt_exp(u)); end
    end
    reset = 1'b0;
    set_idle(0);
    set_idle(1);
  endtask

  task automatic test_load_use(input int u);
    int lat;
    lat = (u == 0) ? 1 : 3;
    do_reset();
    set_instr(u, 1'b1, 32'h100, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd8);
    #1;
    total++; if (stall_o[u] !== 1'b0) begin bad++; $display("FAIL lu_lw_stall u=%0d got=%0b exp=0", u, stall_o[u]); end
    cyc();
    set_instr(u, 1'b1, 32'h200, 5'd8, 1'b1, 5'd10, 1'b1, 1'b0, 5'd9);
    #1;
    total++; if (ex_valid_o[u] !== 1'b1 || ex_payload_o[u] !== 32'h100 || ex_dst_o[u] !== 5'd8 || ex_mr_o[u] !== 1'b1)
      begin bad++; $display("FAIL lu_lw_in_ex u=%0d got v=%0b p=%h d=%0d m=%0b exp v=1 p=100 d=8 m=1", u, ex_valid_o[u], ex_payload_o[u], ex_dst_o[u], ex_mr_o[u]); end
    total++; if (stall_o[u] !== 1'b1) begin bad++; $display("FAIL lu_stall_first u=%0d got=%0b exp=1", u, stall_o[u]); end
    for (int i = 1; i < lat; i++) begin
      cyc(); #1;
      total++; if (ex_valid_o[u] !== 1'b0 || stall_o[u] !== 1'b1)
        begin bad++; $display("FAIL lu_stall_held u=%0d cyc=%0d got v=%0b s=%0b exp v=0 s=1", u, i, ex_valid_o[u], stall_o[u]); end
    end
    for (int i = 0; i < lat; i++) bump(u);
    cyc(); #1;
    total++; if (ex_valid_o[u] !== 1'b0 || stall_o[u] !== 1'b0)
      begin bad++; $display("FAIL lu_release u=%0d got v=%0b s=%0b exp v=0 s=0", u, ex_valid_o[u], stall_o[u]); end
    cyc();
    set_idle(u);
    #1;
    total++; if (ex_valid_o[u] !== 1'b1 || ex_payload_o[u] !== 32'h200 || ex_dst_o[u] !== 5'd9 || ex_mr_o[u] !== 1'b0)
      begin bad++; $display("FAIL lu_add_in_ex u=%0d got v=%0b p=%h d=%0d m=%0b exp v=1 p=200 d=9 m=0", u, ex_valid_o[u], ex_payload_o[u], ex_dst_o[u], ex_mr_o[u]); end
    total++; if (cnt_o[u] !== cnt_exp(u)) begin bad++; $display("FAIL lu_cnt u=%0d got=%0d exp=%0d", u, cnt_o[u], cnt_exp(u)); end
  endtask

  task automatic test_no_hazard();
    do_reset();
    set_instr(1, 1'b1, 32'h300, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd8);
    cyc();
    set_instr(1, 1'b1, 32'h301, 5'd9, 1'b1, 5'd8, 1'b0, 1'b0, 5'd10);
    #1;
    total++; if (stall_o[1] !== 1'b0) begin bad++; $display("FAIL nh_rt_unused got=%0b exp=0", stall_o[1]); end
    cyc();
    set_instr(1, 1'b1, 32'h302, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0);
    #1;
    total++; if (ex_valid_o[1] !== 1'b1 || ex_payload_o[1] !== 32'h301)
      begin bad++; $display("FAIL nh_advance got v=%0b p=%h exp v=1 p=301", ex_valid_o[1], ex_payload_o[1]); end
    cyc();
    set_instr(1, 1'b1, 32'h303, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd11);
    #1;
    total++; if (stall_o[1] !== 1'b0) begin bad++; $display("FAIL nh_reg0 got=%0b exp=0", stall_o[1]); end
    cyc();
    set_instr(1, 1'b1, 32'h304, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd8);
    cyc();
    set_instr(1, 1'b1, 32'h305, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 5'd12);
    #1;
    total++; if (stall_o[1] !== 1'b0) begin bad++; $display("FAIL nh_other_reg got=%0b exp=0", stall_o[1]); end
    cyc();
    set_idle(1);
    #1;
    total++; if (ex_valid_o[1] !== 1'b1 || ex_payload_o[1] !== 32'h305)
      begin bad++; $display("FAIL nh_reader_in_ex got v=%0b p=%h exp v=1 p=305", ex_valid_o[1], ex_payload_o[1]); end
    total++; if (cnt_o[1] !== cnt_exp(1)) begin bad++; $display("FAIL nh_cnt got=%0d exp=%0d", cnt_o[1], cnt_exp(1)); end
  endtask

  task automatic test_flush();
    do_reset();
    set_instr(1, 1'b1, 32'h400, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd8);
    cyc();
    set_instr(1, 1'b1, 32'h401, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 5'd9);
    flush[1] = 1'b1;
    #1;
    total++; if (stall_o[1] !== 1'b0) begin bad++; $display("FAIL fl_stall_masked got=%0b exp=0", stall_o[1]); end
    cyc();
    flush[1] = 1'b0;
    #1;
    total++; if (ex_valid_o[1] !== 1'b0 || ex_payload_o[1] !== '0)
      begin bad++; $display("FAIL fl_bubble got v=%0b p=%h exp v=0 p=0", ex_valid_o[1], ex_payload_o[1]); end
    total++; if (stall_o[1] !== 1'b1) begin bad++; $display("FAIL fl_sb_shifted got=%0b exp=1", stall_o[1]); end
    total++; if (cnt_o[1] !== cnt_exp(1)) begin bad++; $display("FAIL fl_not_counted got=%0d exp=%0d", cnt_o[1], cnt_exp(1)); end
    cyc();
    bump(1);
    set_idle(1);
    #1;
    total++; if (cnt_o[1] !== cnt_exp(1)) begin bad++; $display("FAIL fl_cnt_after got=%0d exp=%0d", cnt_o[1], cnt_exp(1)); end
  endtask

  task automatic test_hold();
    do_reset();
    set_instr(1, 1'b1, 32'hABCD, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd8);
    cyc();
    set_instr(1, 1'b1, 32'h501, 5'd8, 1'b1, 5'd8, 1'b1, 1'b0, 5'd9);
    ex_hold[1] = 1'b1;
    #1;
    total++; if (stall_o[1] !== 1'b1) begin bad++; $display("FAIL hd_stall got=%0b exp=1", stall_o[1]); end
    cyc(); #1;
    total++; if (ex_valid_o[1] !== 1'b1 || ex_payload_o[1] !== 32'hABCD || stall_o[1] !== 1'b1)
      begin bad++; $display("FAIL hd_frozen got v=%0b p=%h s=%0b exp v=1 p=abcd s=1", ex_valid_o[1], ex_payload_o[1], stall_o[1]); end
    cyc();
    ex_hold[1] = 1'b0;
    #1;
    total++; if (ex_valid_o[1] !== 1'b1 || ex_payload_o[1] !== 32'hABCD || stall_o[1] !== 1'b1)
      begin bad++; $display("FAIL hd_after_drop got v=%0b p=%h s=%0b exp v=1 p=abcd s=1", ex_valid_o[1], ex_payload_o[1], stall_o[1]); end
    for (int i = 0; i < 2; i++) begin
      cyc(); #1;
      total++; if (ex_valid_o[1] !== 1'b0 || stall_o[1] !== 1'b1)
        begin bad++; $display("FAIL hd_pending i=%0d got v=%0b s=%0b exp v=0 s=1", i, ex_valid_o[1], stall_o[1]); end
    end
    for (int i = 0; i < 3; i++) bump(1);
    cyc(); #1;
    total++; if (stall_o[1] !== 1'b0) begin bad++; $display("FAIL hd_release got=%0b exp=0", stall_o[1]); end
    cyc();
    set_idle(1);
    #1;
    total++; if (ex_valid_o[1] !== 1'b1 || ex_payload_o[1] !== 32'h501)
      begin bad++; $display("FAIL hd_reader_in_ex got v=%0b p=%h exp v=1 p=501", ex_valid_o[1], ex_payload_o[1]); end
    total++; if (cnt_o[1] !== cnt_exp(1)) begin bad++; $display("FAIL hd_cnt got=%0d exp=%0d", cnt_o[1], cnt_exp(1)); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    set_instr(1, 1'b1, 32'h600, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd8);
    cyc();
    set_instr(1, 1'b1, 32'h601, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 5'd9);
    cyc();
    bump(1);
    #1;
    total++; if (cnt_o[1] !== cnt_exp(1)) begin bad++; $display("FAIL rm_cnt_before got=%0d exp=%0d", cnt_o[1], cnt_exp(1)); end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    exp_cnt[1] = 0;
    #1;
    total++; if (ex_valid_o[1] !== 1'b0 || ex_payload_o[1] !== '0 || ex_dst_o[1] !== 5'd0 || ex_mr_o[1] !== 1'b0)
      begin bad++; $display("FAIL rm_outputs got v=%0b p=%h d=%0d m=%0b exp all 0", ex_valid_o[1], ex_payload_o[1], ex_dst_o[1], ex_mr_o[1]); end
    total++; if (stall_o[1] !== 1'b0) begin bad++; $display("FAIL rm_stall got=%0b exp=0", stall_o[1]); end
    total++; if (cnt_o[1] !== cnt_exp(1)) begin bad++; $display("FAIL rm_cnt got=%0d exp=%0d", cnt_o[1], cnt_exp(1)); end
    set_idle(1);
  endtask

  task automatic test_saturate();
    do_reset();
    for (int n = 0; n < 8; n++) begin
      set_instr(0, 1'b1, 32'h700 + 32'(n), 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd8);
      cyc();
      set_instr(0, 1'b1, 32'h800 + 32'(n), 5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 5'd9);
      #1;
      total++; if (stall_o[0] !== 1'b1) begin bad++; $display("FAIL sat_stall n=%0d got=%0b exp=1", n, stall_o[0]); end
      cyc();
      bump(0);
      cyc();
      if (n == 6) begin
        total++; if (cnt_o[0] !== cnt_exp(0)) begin bad++; $display("FAIL sat_reach got=%0d exp=%0d", cnt_o[0], cnt_exp(0)); end
      end
    end
    set_idle(0);
    #1;
    total++; if (cnt_o[0] !== cnt_exp(0)) begin bad++; $display("FAIL sat_hold got=%0d exp=%0d", cnt_o[0], cnt_exp(0)); end
  endtask

  // random stream; scoreboard holds accepted payloads in order, stall predicted from load issue times
  task automatic test_back_to_back(input int u);
    int lat;
    int ld_edge [32];
    logic [4:0] pick [4];
    logic c_v, c_rsu, c_rtu, c_mr;
    logic [DW-1:0] c_pl, expd;
    logic [4:0] c_rs, c_rt, c_dst;
    bit need, haz;
    lat = (u == 0) ? 1 : 3;
    pick[0] = 5'd0; pick[1] = 5'd8; pick[2] = 5'd9; pick[3] = 5'd10;
    for (int r = 0; r < 32; r++) ld_edge[r] = -100;
    exp_q.delete();
    do_reset();
    need = 1'b1;
    c_v = 0; c_rsu = 0; c_rtu = 0; c_mr = 0; c_pl = '0; c_rs = '0; c_rt = '0; c_dst = '0;
    for (int e = 0; e < 80; e++) begin
      if (need) begin
        c_v = ($urandom_range(0, 9) < 8);
        c_pl = {16'(e + 256 * u), 16'($urandom)};
        c_rs = pick[$urandom_range(0, 3)];
        c_rt = pick[$urandom_range(0, 3)];
        c_rsu = 1'($urandom_range(0, 1));
        c_rtu = 1'($urandom_range(0, 1));
        c_mr = 1'($urandom_range(0, 1));
        c_dst = pick[$urandom_range(0, 2)];
      end
      set_instr(u, c_v, c_pl, c_rs, c_rsu, c_rt, c_rtu, c_mr, c_dst);
      #1;
      if (ex_valid_o[u] === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL b2b_extra u=%0d got=%h exp=none", u, ex_payload_o[u]);
        end else begin
          expd = exp_q.pop_front();
          if (ex_payload_o[u] !== expd) begin bad++; $display("FAIL b2b_payload u=%0d got=%h exp=%h", u, ex_payload_o[u], expd); end
        end
      end
      haz = c_v && ((c_rsu && (c_rs != 5'd0) && ((e - ld_edge[c_rs]) < lat)) ||
                    (c_rtu && (c_rt != 5'd0) && ((e - ld_edge[c_rt]) < lat)));
      total++; if (stall_o[u] !== haz) begin bad++; $display("FAIL b2b_stall u=%0d cyc=%0d got=%0b exp=%0b", u, e, stall_o[u], haz); end
      if (haz) begin
        bump(u);
        need = 1'b0;
      end else begin
        need = 1'b1;
        if (c_v) begin
          exp_q.push_back(c_pl);
          if (c_mr && (c_dst != 5'd0)) ld_edge[c_dst] = e + 1;
        end
      end
      cyc();
    end
    set_idle(u);
    for (int i = 0; i < 2; i++) begin
      #1;
      if (ex_valid_o[u] === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL b2b_extra u=%0d got=%h exp=none", u, ex_payload_o[u]);
        end else begin
          expd = exp_q.pop_front();
          if (ex_payload_o[u] !== expd) begin bad++; $display("FAIL b2b_payload u=%0d got=%h exp=%h", u, ex_payload_o[u], expd); end
        end
      end
      cyc();
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_drain u=%0d got=%0d left exp=0", u, exp_q.size()); end
    total++; if (cnt_o[u] !== cnt_exp(u)) begin bad++; $display("FAIL b2b_cnt u=%0d got=%0d exp=%0d", u, cnt_o[u], cnt_exp(u)); end
  endtask

  initial begin
    exp_cnt[0] = 0;
    exp_cnt[1] = 0;
    reset = 1'b1;
    set_idle(0);
    set_idle(1);
    test_reset();
    test_load_use(0);
    test_load_use(1);
    test_no_hazard();
    test_flush();
    test_hold();
    test_reset_mid_stall();
    test_saturate();
    test_back_to_back(0);
    test_back_to_back(1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
